// File: rtl/ysyx_22040125_pkg.sv
// Shared definitions for the ysyx_22040125 fetch front end:
// pc_sel encodings, fetch FSM states and reset defaults.
package ysyx_22040125_pkg;

    localparam logic [2:0] PC_SEL_SEQ  = 3'b000;
    localparam logic [2:0] PC_SEL_JAL  = 3'b001;
    localparam logic [2:0] PC_SEL_BR   = 3'b010;
    localparam logic [2:0] PC_SEL_JALR = 3'b011;
    localparam logic [2:0] PC_SEL_TRAP = 3'b100;

    localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } fetch_state_e;

endpackage

// File: rtl/ysyx_22040125_if_fetch_if.sv
// Single-outstanding instruction memory port (req/gnt/rvalid).
// The fetch stage is the master, the instruction memory the slave.
interface ysyx_22040125_if_fetch_if;

    logic        req;
    logic [63:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );

endinterface

// File: rtl/ysyx_22040125_if_next_pc.sv
// Next-PC target mux and redirect decode driven by the ID-stage pc_sel.
// Unused encodings (101-111) behave as sequential fetch.
module ysyx_22040125_if_next_pc
    import ysyx_22040125_pkg::*;
(
    input  logic [2:0]  pc_sel,
    input  logic [63:0] cpu_dnpc_in1,
    input  logic [63:0] cpu_dnpc_in2,
    input  logic [63:0] csr_dnpc,
    output logic        redirect,
    output logic [63:0] target
);

    always_comb begin
        redirect = 1'b1;
        target   = cpu_dnpc_in1;
        case (pc_sel)
            PC_SEL_JAL,
            PC_SEL_BR:   target = cpu_dnpc_in1;
            PC_SEL_JALR: target = cpu_dnpc_in2;
            PC_SEL_TRAP: target = csr_dnpc;
            default:     redirect = 1'b0;
        endcase
    end

endmodule

// File: rtl/ysyx_22040125_if_fetch.sv
// IF stage: owns the fetch PC, issues one outstanding imem request at a time,
// buffers a response while ID stalls and drives the IF/ID register.
module ysyx_22040125_if_fetch
    import ysyx_22040125_pkg::*;
#(
    parameter logic [63:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [2:0]                    pc_sel,
    input  logic [63:0]                   cpu_dnpc_in1,
    input  logic [63:0]                   cpu_dnpc_in2,
    input  logic [63:0]                   csr_dnpc,
    input  logic                          id_stall,
    ysyx_22040125_if_fetch_if.master      imem,
    output logic [63:0]                   if_reg_pc,
    output logic [31:0]                   if_reg_inst,
    output logic                          if_reg_valid
);

    fetch_state_e state, state_n;
    logic [63:0]  fetch_pc;
    logic [63:0]  req_pc;
    logic         drop, drop_n;
    logic         buf_valid, buf_valid_n;
    logic [31:0]  buf_inst;
    logic         buf_load;
    logic         deliver;
    logic [31:0]  deliver_inst;
    logic         redirect;
    logic [63:0]  target;
    logic         granted;

    ysyx_22040125_if_next_pc u_next_pc (
        .pc_sel       (pc_sel),
        .cpu_dnpc_in1 (cpu_dnpc_in1),
        .cpu_dnpc_in2 (cpu_dnpc_in2),
        .csr_dnpc     (csr_dnpc),
        .redirect     (redirect),
        .target       (target)
    );

    assign imem.req  = (state == S_REQ);
    assign imem.addr = fetch_pc;
    assign granted   = (state == S_REQ) && imem.gnt;

    always_comb begin
        state_n      = state;
        drop_n       = drop;
        buf_valid_n  = buf_valid;
        buf_load     = 1'b0;
        deliver      = 1'b0;
        deliver_inst = imem.rdata;
        case (state)
            S_IDLE: state_n = S_REQ;
            S_REQ: begin
                // A request granted alongside a redirect is already stale.
                if (imem.gnt) begin
                    state_n = S_WAIT;
                    drop_n  = redirect;
                end
            end
            S_WAIT: begin
                if (imem.rvalid) begin
                    state_n = S_REQ;
                    drop_n  = 1'b0;
                    if (!redirect && !drop) begin
                        if (!id_stall) begin
                            deliver = 1'b1;
                        end else begin
                            buf_load    = 1'b1;
                            buf_valid_n = 1'b1;
                            state_n     = S_HOLD;
                        end
                    end
                end else if (redirect) begin
                    drop_n = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    state_n = S_REQ;
                end else if (!id_stall) begin
                    deliver      = 1'b1;
                    deliver_inst = buf_inst;
                    buf_valid_n  = 1'b0;
                    state_n      = S_REQ;
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (redirect) begin
            buf_valid_n = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            drop      <= 1'b0;
            buf_valid <= 1'b0;
            fetch_pc  <= RESET_PC;
        end else begin
            state     <= state_n;
            drop      <= drop_n;
            buf_valid <= buf_valid_n;
            if (redirect) begin
                fetch_pc <= target;
            end else if (granted) begin
                fetch_pc <= fetch_pc + 64'd4;
            end
        end
    end

    // req_pc stays valid until the next grant, which cannot happen before the
    // buffered instruction leaves S_HOLD, so it also serves as the buffer pc.
    always_ff @(posedge clk) begin
        if (granted) begin
            req_pc <= fetch_pc;
        end
        if (buf_load) begin
            buf_inst <= imem.rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_reg_pc    <= 64'd0;
            if_reg_inst  <= NOP_INST;
            if_reg_valid <= 1'b0;
        end else if (redirect) begin
            if_reg_inst  <= NOP_INST;
            if_reg_valid <= 1'b0;
        end else if (!id_stall) begin
            if (deliver) begin
                if_reg_pc    <= req_pc;
                if_reg_inst  <= deliver_inst;
                if_reg_valid <= 1'b1;
            end else begin
                if_reg_inst  <= NOP_INST;
                if_reg_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22040125_if_fetch.sv
// Randomized scoreboard bench for ysyx_22040125_if_fetch with a
// transaction-level fetch model and a random-latency instruction memory.
`timescale 1ns/1ps
module tb_ysyx_22040125_if_fetch;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } fetch_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  pc_sel = 3'd0;
    logic [63:0] dnpc1 = 64'd0, dnpc2 = 64'd0, csr = 64'd0;
    logic        id_stall = 1'b0;
    logic [63:0] if_reg_pc;
    logic [31:0] if_reg_inst;
    logic        if_reg_valid;

    ysyx_22040125_if_fetch_if imem ();

    ysyx_22040125_if_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .pc_sel       (pc_sel),
        .cpu_dnpc_in1 (dnpc1),
        .cpu_dnpc_in2 (dnpc2),
        .csr_dnpc     (csr),
        .id_stall     (id_stall),
        .imem         (imem),
        .if_reg_pc    (if_reg_pc),
        .if_reg_inst  (if_reg_inst),
        .if_reg_valid (if_reg_valid)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    fetch_t      exp_q[$];
    logic [63:0] exp_pc = RST_PC;
    bit          busy = 1'b0;
    logic [63:0] busy_addr = 64'd0;
    bit          mon_en = 1'b0;

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0001;
    endfunction

    function automatic bit is_redir(input logic [2:0] s);
        return (s >= 3'd1) && (s <= 3'd4);
    endfunction

    function automatic logic [63:0] tgt_of(input logic [2:0] s, input logic [63:0] a, b, c);
        if (s == 3'd3) return b;
        if (s == 3'd4) return c;
        return a;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One cycle of stimulus: drive at negedge, update the model for the coming edge.
    task automatic step(input logic [2:0] sel, input logic [63:0] t1, t2, tc,
                        input logic stall, input int gnt_pct, input int rv_pct);
        bit rv, g;
        @(negedge clk);
        pc_sel   = sel;
        dnpc1    = t1;
        dnpc2    = t2;
        csr      = tc;
        id_stall = stall;
        rv = busy && ($urandom_range(99) < rv_pct);
        imem.rvalid = rv;
        imem.rdata  = rv ? inst_of(busy_addr) : $urandom;
        g = imem.req && !busy && ($urandom_range(99) < gnt_pct);
        imem.gnt = g;
        if (g) begin
            check("imem_addr", imem.addr, exp_pc);
            exp_q.push_back('{pc: exp_pc, inst: inst_of(exp_pc)});
        end
        if (is_redir(sel)) begin
            exp_q.delete();
            exp_pc = tgt_of(sel, t1, t2, tc);
        end else if (g) begin
            exp_pc = exp_pc + 64'd4;
        end
        if (rv) busy = 1'b0;
        if (g) begin
            busy      = 1'b1;
            busy_addr = imem.addr;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_pc      = RST_PC;
        busy        = 1'b0;
        imem.gnt    = 1'b0;
        imem.rvalid = 1'b0;
    endtask

    // Monitor: compares IF/ID against the scoreboard after every edge.
    logic        mon_st, mon_rd, mon_r;
    logic [63:0] prev_pc;
    logic [31:0] prev_inst;
    logic        prev_valid;
    fetch_t      mon_e;

    always @(posedge clk) begin
        mon_st = id_stall;
        mon_rd = is_redir(pc_sel);
        mon_r  = rst;
        #1;
        if (mon_en && !mon_r && !rst) begin
            if (mon_rd) begin
                check("flush_valid", {63'd0, if_reg_valid}, 64'd0);
                check("flush_inst", {32'd0, if_reg_inst}, {32'd0, NOP});
            end else if (mon_st) begin
                check("hold_valid", {63'd0, if_reg_valid}, {63'd0, prev_valid});
                check("hold_pc", if_reg_pc, prev_pc);
                check("hold_inst", {32'd0, if_reg_inst}, {32'd0, prev_inst});
            end else if (if_reg_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_inst: got pc %h inst %h, expected no instruction",
                             if_reg_pc, if_reg_inst);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("if_pc", if_reg_pc, mon_e.pc);
                    check("if_inst", {32'd0, if_reg_inst}, {32'd0, mon_e.inst});
                end
            end else begin
                check("bubble_inst", {32'd0, if_reg_inst}, {32'd0, NOP});
            end
        end
        prev_pc    = if_reg_pc;
        prev_inst  = if_reg_inst;
        prev_valid = if_reg_valid;
    end

    initial begin
        logic [2:0] sel;
        imem.gnt    = 1'b0;
        imem.rvalid = 1'b0;
        imem.rdata  = 32'd0;

        // Reset values
        #3 rst = 1'b1;
        #1;
        check("rst_req", {63'd0, imem.req}, 64'd0);
        check("rst_valid", {63'd0, if_reg_valid}, 64'd0);
        check("rst_pc", if_reg_pc, 64'd0);
        check("rst_inst", {32'd0, if_reg_inst}, {32'd0, NOP});
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        mon_en = 1'b1;

        // Back-to-back sequential fetch
        for (int i = 0; i < 8; i++) step(3'd0, 0, 0, 0, 1'b0, 100, 100);
        // Stall while a response arrives, then release
        for (int i = 0; i < 5; i++) step(3'd0, 0, 0, 0, 1'b1, 100, 100);
        for (int i = 0; i < 4; i++) step(3'd0, 0, 0, 0, 1'b0, 100, 100);
        // Branch redirect while waiting for a response
        for (int i = 0; i < 10 && !busy; i++) step(3'd0, 0, 0, 0, 1'b0, 100, 0);
        step(3'b010, 64'h8000_0100, 0, 0, 1'b0, 100, 0);
        for (int i = 0; i < 6; i++) step(3'd0, 0, 0, 0, 1'b0, 100, 100);
        // jalr redirect on the same cycle as a grant
        for (int i = 0; i < 10 && !(imem.req && !busy); i++) step(3'd0, 0, 0, 0, 1'b0, 0, 100);
        step(3'b011, 0, 64'h8000_0200, 0, 1'b0, 100, 0);
        for (int i = 0; i < 6; i++) step(3'd0, 0, 0, 0, 1'b0, 100, 100);
        // Trap to the top of the address space, then wrap
        step(3'b100, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 0, 100);
        for (int i = 0; i < 8; i++) step(3'd0, 0, 0, 0, 1'b0, 100, 100);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            sel = ($urandom_range(99) < 85) ? 3'd0 : 3'($urandom_range(1, 7));
            step(sel, {32'h0, $urandom}, {32'h0, $urandom}, {$urandom, $urandom},
                 ($urandom_range(99) < 30), 60, 50);
        end

        // Asynchronous reset with a response pending
        for (int i = 0; i < 20 && !busy; i++) step(3'd0, 0, 0, 0, 1'b0, 100, 0);
        check("rst_wait_busy", {63'd0, busy}, 64'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_req", {63'd0, imem.req}, 64'd0);
        check("arst_valid", {63'd0, if_reg_valid}, 64'd0);
        check("arst_pc", if_reg_pc, 64'd0);
        check("arst_inst", {32'd0, if_reg_inst}, {32'd0, NOP});
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) step(3'd0, 0, 0, 0, 1'b0, 100, 100);

        // Drain: no new grants, every outstanding instruction must appear
        for (int i = 0; i < 50 && (exp_q.size() != 0 || busy); i++) step(3'd0, 0, 0, 0, 1'b0, 0, 100);
        @(negedge clk);
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
